envelope_decay_release: RTL

//  Second half of the synth ADSR envelope: downstream end of the attack stage's start_decay/shift handoff.

---
 rtl/env_pkg.sv | 15 +
 rtl/env_rate_div.sv | 30 +++
 rtl/envelope_decay_release.sv | 136 +++++++++++++
 3 files changed

// File: rtl/env_pkg.sv
// Shared definitions for the ADSR decay/release envelope: state encoding and default widths.
package env_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECAY   = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

  localparam int DEF_DATA_W    = 20;
  localparam int DEF_SHIFT_W   = 5;
  localparam int DEF_MAX_SHIFT = 20;

endpackage

// File: rtl/env_rate_div.sv
// Envelope-rate tick divider: emits one step every div_val rate ticks, restartable by clear.
module env_rate_div #(
  parameter int DIV   = 8,
  parameter int CNT_W = $clog2(DIV + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] div_val,
  output logic             step
);

  logic [CNT_W-1:0] cnt;

  assign step = tick && (cnt == div_val - CNT_W'(1));

  // clear has priority so a state change wins over a coincident step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      if (step) cnt <= '0;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/envelope_decay_release.sv
// Decay/sustain/release half of the ADSR envelope; out = in >> shift, registered.
// Optional build macro ENV_RETRIGGER_EN: note_on rising edge during RELEASE returns to IDLE.
module envelope_decay_release
  import env_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SHIFT_W     = DEF_SHIFT_W,
  parameter int MAX_SHIFT   = DEF_MAX_SHIFT,
  parameter int DECAY_DIV   = 4,
  parameter int RELEASE_DIV = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rate_tick,
  input  logic               note_on,
  input  logic               start_decay,
  input  logic [SHIFT_W-1:0] sustain_shift,
  input  logic [DATA_W-1:0]  in,
  output logic [DATA_W-1:0]  out,
  output logic [SHIFT_W-1:0] shift_amount,
  output logic               busy,
  output logic               env_done
);

  localparam int MAX_DIV = (DECAY_DIV > RELEASE_DIV) ? DECAY_DIV : RELEASE_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV + 1);
  localparam logic [SHIFT_W-1:0] MAX_S = SHIFT_W'(MAX_SHIFT);

  env_state_t         state;
  env_state_t         nxt_state;
  logic [SHIFT_W-1:0] shift;
  logic [SHIFT_W-1:0] sus_q;
  logic               sd_q;
  logic               sd_rise;
  logic               step;
  logic [CNT_W-1:0]   div_val;
  logic [DATA_W-1:0]  out_p1;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    if (32'(s) > MAX_SHIFT) return MAX_S;
    return s;
  endfunction

  assign sd_rise      = start_decay & ~sd_q;
  assign div_val      = (state == ST_RELEASE) ? CNT_W'(RELEASE_DIV) : CNT_W'(DECAY_DIV);
  assign shift_amount = shift;
  assign out          = out_p1;

`ifdef ENV_RETRIGGER_EN
  logic nr_q;
  logic nr_rise;

  assign nr_rise = note_on & ~nr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nr_q <= 1'b0;
    else        nr_q <= note_on;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sd_q <= 1'b0;
    else        sd_q <= start_decay;
  end

  env_rate_div #(
    .DIV   (MAX_DIV),
    .CNT_W (CNT_W)
  ) u_rate_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (nxt_state != state),
    .tick    (rate_tick),
    .div_val (div_val),
    .step    (step)
  );

  always_comb begin
    nxt_state = state;
    unique case (state)
      ST_IDLE:    if (sd_rise && note_on) nxt_state = ST_DECAY;
      ST_DECAY:   if (!note_on)            nxt_state = ST_RELEASE;
                  else if (shift == sus_q) nxt_state = ST_SUSTAIN;
      ST_SUSTAIN: if (!note_on)            nxt_state = ST_RELEASE;
      ST_RELEASE: begin
        if (shift == MAX_S) nxt_state = ST_IDLE;
`ifdef ENV_RETRIGGER_EN
        else if (nr_rise)   nxt_state = ST_IDLE;
`endif
      end
      default:    nxt_state = ST_IDLE;
    endcase
  end

  // Shift only moves while the state is unchanged; exits freeze it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shift    <= MAX_S;
      sus_q    <= '0;
      busy     <= 1'b0;
      env_done <= 1'b0;
    end else begin
      state    <= nxt_state;
      busy     <= (nxt_state != ST_IDLE);
      env_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (nxt_state == ST_DECAY) begin
            shift <= '0;
            sus_q <= clamp_shift(sustain_shift);
          end
        end
        ST_DECAY: begin
          if (nxt_state == ST_DECAY && step && shift < sus_q) shift <= shift + SHIFT_W'(1);
        end
        ST_RELEASE: begin
          if (nxt_state == ST_RELEASE) begin
            if (step && shift < MAX_S) shift <= shift + SHIFT_W'(1);
          end else if (shift == MAX_S) begin
            env_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output stage: one register after the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     out_p1 <= '0;
    else if (32'(shift) >= DATA_W)  out_p1 <= '0;
    else                            out_p1 <= in >> shift;
  end

endmodule
